tile_round_sequencer: RTL and testbench
=======================================

Name: tile_round_sequencer

Overview:
- Game-level controller for the three-lane tile datapath.
- Generates one pseudo-random 3-lane tile row per timed window and drives it to the hit checker.
- Collects the checker's per-window hit count, keeps total score and lives, and shortens the window as levels advance.
- Sits between the start button / LFSR source and the checker; its outputs also feed the display logic.

Parameters:
- WIN_INIT, 1000, initial window length in div_clk cycles (>= WIN_MIN).
- WIN_MIN, 250, minimum window length.
- WIN_STEP, 50, window reduction per level-up.
- LEVEL_ROWS, 16, completed rows per level-up.
- LIVES, 3, lives at game start (1..7).
- SEED, 8'hA5, LFSR reset value; 8'h00 is replaced by 8'h01.
- TIMEOUT, 4, cycles to wait for score_valid after window end.

Ports:
- div_clk  in  1  clock.
- rst  in  1  reset, asynchronous, active-low.
- start_n  in  1  start button, active-low, synchronous to div_clk.
- hit_score  in  2  lanes hit in the last window (from checker).
- score_valid  in  1  one-cycle strobe; hit_score is valid.
- row  out  3  current tile row, bit2 = lane1 … bit0 = lane3.
- row_valid  out  1  high while a window is open.
- window_end  out  1  one-cycle pulse on the last cycle of a window.
- total_score  out  16  accumulated score, saturating.
- lives  out  3  remaining lives.
- level  out  4  current level, saturating at 15.
- game_over  out  1  high in OVER.

Behaviour:
- Reset (async, rst=0) values:
  - row=0, row_valid=0, window_end=0, total_score=0, lives=LIVES, level=0, game_over=0.
  - Internal: state=IDLE, LFSR=SEED, win_len=WIN_INIT, win_cnt=0, rows_done=0, start_prev=1.
  - Reset mid-game aborts immediately; no partial score is kept.
- Start press: start_prev==1 && start_n==0 (falling edge, registered). Presses are ignored in LOAD, PLAY and SETTLE.
- IDLE:
  - Outputs hold reset values.
  - On a press: total_score=0, lives=LIVES, level=0, win_len=WIN_INIT, rows_done=0; go to LOAD.
- LOAD (1 cycle):
  - Advance the LFSR once (8-bit Fibonacci, taps 8,6,5,4, shift left, feedback into bit0).
  - row <= new LFSR[2:0]; if that is 3'b000, row <= 3'b100.
  - win_cnt <= 0; go to PLAY.
- PLAY:
  - row_valid=1; win_cnt increments each cycle.
  - When win_cnt == win_len-1: window_end=1 for that cycle, then go to SETTLE.
  - Window length is exactly win_len cycles.
- SETTLE:
  - row_valid=0; row holds its value; wait up to TIMEOUT cycles for score_valid.
  - If score_valid arrives in the same cycle as window_end, it is accepted in the first SETTLE cycle only if still asserted; earlier strobes are ignored.
  - h = min(hit_score, popcount(row)); a timeout gives h=0.
  - total_score <= min(total_score + h, 16'hFFFF).
  - If h < popcount(row): lives decrements.
  - rows_done increments. When it reaches LEVEL_ROWS: rows_done=0, level=min(level+1, 15), win_len=max(win_len-WIN_STEP, WIN_MIN).
  - Next state: OVER if lives became 0, else LOAD.
  - Score, lives and level all update in the same cycle as the transition.
- OVER:
  - game_over=1, row=0, row_valid=0; total_score and level hold.
  - A start press behaves as in IDLE: counters clear, game_over drops, go to LOAD.
- Hazards:
  - A score_valid strobe outside SETTLE is ignored.
  - win_len never goes below WIN_MIN; level 15 with further rows keeps win_len unchanged.

Test Plan:
- Reset, then idle for 20 cycles with start_n=1 -> row=0, row_valid=0, lives=3, total_score=0, game_over=0 throughout.
- WIN_INIT=8: press start -> LOAD one cycle later, row_valid high exactly 8 cycles, window_end pulses on the 8th; row nonzero and equal to the masked LFSR value computed from SEED=A5.
- In SETTLE, return score_valid with hit_score = popcount(row) -> total_score increases by popcount, lives stays 3; hit_score=3 on a single-lane row -> +1 only (clamped).
- No score_valid for 4 cycles after window_end -> h=0, lives decrements to 2; repeat twice more -> lives=0, game_over=1, row=0; press start -> lives=3, score=0, game restarts.
- LEVEL_ROWS=2, WIN_INIT=300, WIN_MIN=250, WIN_STEP=50: complete 4 rows -> level=2, row_valid windows measure 300, 300, 250, 250, 250 cycles.
- Assert rst low mid-PLAY with score=5 -> all outputs return to reset values asynchronously; after release, a start press gives a full new game with the LFSR restarted at SEED.

Source files
------------

// File: rtl/tile_round_if.sv
// Handshake bundle between the tile round sequencer and its environment
// (start button, hit checker, display logic).
//   start_n      start button, active-low, synchronous to div_clk
//   hit_score    lanes hit in the last window, from the hit checker
//   score_valid  one-cycle strobe qualifying hit_score
//   row          current tile row, bit2 = lane1 .. bit0 = lane3
//   row_valid    high while a window is open
//   window_end   one-cycle pulse on the last cycle of a window
//   total_score  accumulated score, saturating at 16'hFFFF
//   lives        remaining lives
//   level        current level, saturating at 15
//   game_over    high while the game is over
// master: the sequencer. slave: the environment driving it.
interface tile_round_if;
  logic        start_n;
  logic [1:0]  hit_score;
  logic        score_valid;
  logic [2:0]  row;
  logic        row_valid;
  logic        window_end;
  logic [15:0] total_score;
  logic [2:0]  lives;
  logic [3:0]  level;
  logic        game_over;

  modport master (
    input  start_n, hit_score, score_valid,
    output row, row_valid, window_end, total_score, lives, level, game_over
  );

  modport slave (
    output start_n, hit_score, score_valid,
    input  row, row_valid, window_end, total_score, lives, level, game_over
  );
endinterface

// File: rtl/tile_round_sequencer.sv
// Game-level controller for the three-lane tile datapath. Each round it
// draws a pseudo-random 3-lane row from an 8-bit LFSR, holds it for a timed
// window, then collects the checker's hit count, updating score, lives and
// level. Windows shorten by WIN_STEP every LEVEL_ROWS completed rows.
// Ports:
//   div_clk  clock
//   rst      asynchronous, active-low reset
//   bus      tile_round_if.master (start button, checker result, row and
//            game status outputs)
module tile_round_sequencer #(
  parameter int unsigned WIN_INIT   = 1000,
  parameter int unsigned WIN_MIN    = 250,
  parameter int unsigned WIN_STEP   = 50,
  parameter int unsigned LEVEL_ROWS = 16,
  parameter int unsigned LIVES      = 3,
  parameter logic [7:0]  SEED       = 8'hA5,
  parameter int unsigned TIMEOUT    = 4
) (
  input logic         div_clk,
  input logic         rst,
  tile_round_if.master bus
);

  localparam int WW = $clog2(WIN_INIT + 1);
  localparam int RW = $clog2(LEVEL_ROWS + 1);
  localparam int TW = $clog2(TIMEOUT + 1);

  // An all-zero seed would lock the LFSR up.
  localparam logic [7:0] SEED_EFF = (SEED == 8'h00) ? 8'h01 : SEED;

  localparam logic [2:0] S_IDLE   = 3'd0;
  localparam logic [2:0] S_LOAD   = 3'd1;
  localparam logic [2:0] S_PLAY   = 3'd2;
  localparam logic [2:0] S_SETTLE = 3'd3;
  localparam logic [2:0] S_OVER   = 3'd4;

  logic [2:0]    state;
  logic [7:0]    lfsr;
  logic [WW-1:0] win_len;
  logic [WW-1:0] win_cnt;
  logic [RW-1:0] rows_done;
  logic [TW-1:0] settle_cnt;
  logic          start_prev;
  logic [2:0]    row_q;
  logic [15:0]   score_q;
  logic [2:0]    lives_q;
  logic [3:0]    level_q;

  logic          press;
  logic [7:0]    lfsr_next;
  logic [1:0]    row_pop;
  logic          win_last;
  logic          settle_done;
  logic          level_up;
  logic [1:0]    hit_eff;
  logic [16:0]   score_sum;
  logic [15:0]   score_next;
  logic [2:0]    lives_next;
  logic [WW-1:0] win_next;

  assign press     = start_prev & ~bus.start_n;
  // Fibonacci LFSR, taps 8,6,5,4, shifting left into bit 0.
  assign lfsr_next = {lfsr[6:0], lfsr[7] ^ lfsr[5] ^ lfsr[4] ^ lfsr[3]};
  assign row_pop   = 2'(row_q[0]) + 2'(row_q[1]) + 2'(row_q[2]);
  assign win_last  = (win_cnt == win_len - WW'(1));
  // A strobe in the final wait cycle still wins over the timeout.
  assign settle_done = bus.score_valid || (settle_cnt == TW'(TIMEOUT - 1));
  assign level_up    = (rows_done == RW'(LEVEL_ROWS - 1));

  always_comb begin
    // NOTE: every signal driven here gets a default before any branch, so
    // no path leaves one unassigned and no latch is inferred.
    hit_eff = 2'd0;
    if (bus.score_valid) begin
      hit_eff = (bus.hit_score < row_pop) ? bus.hit_score : row_pop;
    end
    score_sum  = {1'b0, score_q} + {15'd0, hit_eff};
    score_next = score_sum[16] ? 16'hFFFF : score_sum[15:0];
    lives_next = (hit_eff < row_pop) ? lives_q - 3'd1 : lives_q;
    // Compared in 32 bits so WIN_MIN + WIN_STEP cannot wrap the counter width.
    win_next = (32'(win_len) < WIN_MIN + WIN_STEP) ? WW'(WIN_MIN)
                                                   : win_len - WW'(WIN_STEP);
  end

  always_ff @(posedge div_clk or negedge rst) begin
    if (!rst) begin
      state      <= S_IDLE;
      lfsr       <= SEED_EFF;
      win_len    <= WW'(WIN_INIT);
      win_cnt    <= '0;
      rows_done  <= '0;
      settle_cnt <= '0;
      start_prev <= 1'b1;
      row_q      <= 3'd0;
      score_q    <= 16'd0;
      lives_q    <= 3'(LIVES);
      level_q    <= 4'd0;
    end else begin
      // NOTE: non-blocking assignments make every register here sample the
      // pre-edge values, independent of statement order.
      start_prev <= bus.start_n;
      case (state)
        S_IDLE, S_OVER: begin
          if (press) begin
            score_q   <= 16'd0;
            lives_q   <= 3'(LIVES);
            level_q   <= 4'd0;
            win_len   <= WW'(WIN_INIT);
            rows_done <= '0;
            state     <= S_LOAD;
          end
        end
        S_LOAD: begin
          lfsr    <= lfsr_next;
          // An empty row is never presented; lane 1 is substituted.
          row_q   <= (lfsr_next[2:0] == 3'd0) ? 3'b100 : lfsr_next[2:0];
          win_cnt <= '0;
          state   <= S_PLAY;
        end
        S_PLAY: begin
          if (win_last) begin
            settle_cnt <= '0;
            state      <= S_SETTLE;
          end else begin
            win_cnt <= win_cnt + WW'(1);
          end
        end
        S_SETTLE: begin
          if (settle_done) begin
            score_q <= score_next;
            lives_q <= lives_next;
            if (level_up) begin
              rows_done <= '0;
              // At level 15 the window stays at whatever length it has.
              if (level_q != 4'd15) begin
                level_q <= level_q + 4'd1;
                win_len <= win_next;
              end
            end else begin
              rows_done <= rows_done + RW'(1);
            end
            if (lives_next == 3'd0) begin
              row_q <= 3'd0;
              state <= S_OVER;
            end else begin
              state <= S_LOAD;
            end
          end else begin
            settle_cnt <= settle_cnt + TW'(1);
          end
        end
        default: state <= S_IDLE;
      endcase
    end
  end

  assign bus.row         = row_q;
  assign bus.row_valid   = (state == S_PLAY);
  assign bus.window_end  = (state == S_PLAY) && win_last;
  assign bus.total_score = score_q;
  assign bus.lives       = lives_q;
  assign bus.level       = level_q;
  assign bus.game_over   = (state == S_OVER);

endmodule

// File: tb/tb_tile_round_sequencer.sv
// Randomized scoreboard bench for tile_round_sequencer. The driver plays
// rounds, computes each round's expected row, window length and resulting
// score/lives/level from a game-level model, and queues them. The monitor
// measures each window and checks the queued result once the round settles.
module tb_tile_round_sequencer;

  localparam int          WIN_INIT   = 300;
  localparam int          WIN_MIN    = 250;
  localparam int          WIN_STEP   = 50;
  localparam int          LEVEL_ROWS = 2;
  localparam int          LIVES      = 3;
  localparam int          TIMEOUT    = 4;
  localparam logic [7:0]  SEED       = 8'hA5;
  localparam logic [28:0] RESET_OUTS = {3'd0, 1'b0, 1'b0, 16'd0, 3'(LIVES), 4'd0, 1'b0};

  logic div_clk = 1'b0;
  logic rst;

  tile_round_if bus ();

  tile_round_sequencer #(
    .WIN_INIT   (WIN_INIT),
    .WIN_MIN    (WIN_MIN),
    .WIN_STEP   (WIN_STEP),
    .LEVEL_ROWS (LEVEL_ROWS),
    .LIVES      (LIVES),
    .SEED       (SEED),
    .TIMEOUT    (TIMEOUT)
  ) dut (
    .div_clk (div_clk),
    .rst     (rst),
    .bus     (bus)
  );

  always #5 div_clk = ~div_clk;

  typedef struct {
    int row;
    int len;
    int score;
    int lives;
    int level;
    int over;
  } rec_t;

  rec_t sb[$];
  int   n_total = 0;
  int   n_bad   = 0;

  // Game model state
  logic [7:0] m_lfsr;
  int m_score, m_lives, m_level, m_win, m_rows;

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
    n_total++;
    if (act !== exp) begin
      n_bad++;
      $display("FAIL %s: got %0d expected %0d", name, act, exp);
    end
  endtask

  function automatic logic [28:0] outs();
    return {bus.row, bus.row_valid, bus.window_end, bus.total_score,
            bus.lives, bus.level, bus.game_over};
  endfunction

  // Shift left by one; the new low bit is the parity of taps 8,6,5,4.
  function automatic logic [7:0] lfsr_step(input logic [7:0] s);
    return 8'((s << 1) | {7'd0, ^(s & 8'hB8)});
  endfunction

  task automatic press_start();
    @(posedge div_clk); #1 bus.start_n = 1'b0;
    @(posedge div_clk); #1 bus.start_n = 1'b1;
    m_score = 0; m_lives = LIVES; m_level = 0; m_win = WIN_INIT; m_rows = 0;
    @(negedge div_clk);
    check("load_cycle", {bus.row_valid, bus.game_over, bus.lives, bus.total_score, bus.level},
          {1'b0, 1'b0, 3'(LIVES), 16'd0, 4'd0});
    @(negedge div_clk);
    check("play_opens", bus.row_valid, 1);
  endtask

  // mode 0: no strobe (timeout); 3: strobe from window_end held into first
  // SETTLE cycle; 4: strobe only on the window_end cycle (ignored);
  // other: strobe in SETTLE cycle d+1. hs_in < 0 means "hit every lane".
  task automatic play_round(input int mode, input int hs_in, input int d, input bit spur);
    logic [2:0] r;
    int pc, hs, h, pv;
    bit got, acc;
    rec_t rec;
    m_lfsr = lfsr_step(m_lfsr);
    r  = (m_lfsr[2:0] == 3'd0) ? 3'b100 : m_lfsr[2:0];
    pc = $countones(r);
    hs = (hs_in < 0) ? pc : hs_in;
    rec.row = int'(r);
    rec.len = m_win;
    got = 0; pv = 0;
    for (int c = 0; c < 4 * WIN_INIT; c++) begin
      @(negedge div_clk);
      if (bus.row_valid) pv++;
      // Stray score strobe and start press while the window is open.
      if (spur && pv == 3) begin
        bus.hit_score = 2'd3; bus.score_valid = 1'b1; bus.start_n = 1'b0;
      end else if (spur && pv == 4) begin
        bus.score_valid = 1'b0; bus.start_n = 1'b1;
      end
      if (bus.window_end) begin
        got = 1;
        break;
      end
    end
    if (!got) begin
      check("window_end_seen", 0, 1);
      return;
    end
    acc = !(mode == 0 || mode == 4);
    h = acc ? ((hs < pc) ? hs : pc) : 0;
    m_score = (m_score + h > 65535) ? 65535 : m_score + h;
    if (h < pc) m_lives--;
    m_rows++;
    if (m_rows == LEVEL_ROWS) begin
      m_rows = 0;
      if (m_level < 15) begin
        m_level++;
        m_win = (m_win - WIN_STEP < WIN_MIN) ? WIN_MIN : m_win - WIN_STEP;
      end
    end
    rec.score = m_score;
    rec.lives = m_lives;
    rec.level = m_level;
    rec.over  = (m_lives == 0) ? 1 : 0;
    sb.push_back(rec);
    bus.hit_score = 2'(hs);
    case (mode)
      0: ;
      3: begin
        bus.score_valid = 1'b1;
        @(posedge div_clk); @(posedge div_clk); #1 bus.score_valid = 1'b0;
      end
      4: begin
        bus.score_valid = 1'b1;
        @(posedge div_clk); #1 bus.score_valid = 1'b0;
      end
      default: begin
        repeat (d + 1) @(posedge div_clk);
        #1 bus.score_valid = 1'b1;
        @(posedge div_clk); #1 bus.score_valid = 1'b0;
      end
    endcase
  endtask

  task automatic over_check();
    repeat (TIMEOUT + 4) @(negedge div_clk);
    check("over_flags", {bus.game_over, bus.row, bus.row_valid, bus.lives},
          {1'b1, 3'd0, 1'b0, 3'd0});
    check("over_score", bus.total_score, m_score);
    check("over_level", bus.level, m_level);
    @(posedge div_clk); #1 bus.hit_score = 2'd3; bus.score_valid = 1'b1;
    @(posedge div_clk); #1 bus.score_valid = 1'b0;
    @(negedge div_clk);
    check("over_score_hold", bus.total_score, m_score);
  endtask

  // Monitor: measures each window, then checks the queued round result when
  // the next window opens or game_over rises.
  initial begin
    bit in_win, pending, prev_rv;
    int len;
    logic [2:0] wrow;
    rec_t rec;
    in_win = 0; pending = 0; prev_rv = 0; len = 0; wrow = 3'd0;
    forever begin
      @(negedge div_clk);
      if (!rst) begin
        in_win = 0; pending = 0; prev_rv = 0;
      end else begin
        if (pending && ((bus.row_valid && !prev_rv) || bus.game_over)) begin
          pending = 0;
          if (sb.size() == 0) begin
            check("sb_underflow", 1, 0);
          end else begin
            rec = sb.pop_front();
            check("row", wrow, rec.row);
            check("win_len", len, rec.len);
            check("score", bus.total_score, rec.score);
            check("lives", bus.lives, rec.lives);
            check("level", bus.level, rec.level);
            check("game_over", bus.game_over, rec.over);
          end
        end
        if (bus.window_end && !bus.row_valid) check("window_end_stray", 1, 0);
        if (bus.row_valid) begin
          if (!in_win) begin
            in_win = 1; len = 0; wrow = bus.row;
          end
          len++;
          if (bus.row !== wrow) check("row_stable", bus.row, wrow);
          if (bus.window_end) begin
            in_win = 0; pending = 1;
          end
        end else if (in_win) begin
          check("window_end_missing", 0, 1);
          in_win = 0; pending = 1;
        end
        prev_rv = bus.row_valid;
      end
    end
  end

  initial begin
    #400000;
    $display("FAIL watchdog: got no finish expected finish");
    $fatal(1, "simulation stalled");
  end

  initial begin
    int md;
    rst = 1'b0;
    bus.start_n = 1'b1; bus.score_valid = 1'b0; bus.hit_score = 2'd0;
    m_lfsr = SEED;
    repeat (3) @(negedge div_clk);
    check("reset_outputs", outs(), RESET_OUTS);
    #2 rst = 1'b1;

    // Idle with start released; stray strobes must not move anything.
    for (int i = 0; i < 20; i++) begin
      @(negedge div_clk);
      check("idle_hold", outs(), RESET_OUTS);
      bus.hit_score   = 2'($urandom_range(0, 3));
      bus.score_valid = 1'($urandom_range(0, 1));
    end
    bus.score_valid = 1'b0;

    // Game 1: directed opening rounds, random middle, timeouts to the end.
    press_start();
    for (int r = 0; r < 20 && m_lives > 0; r++) begin
      case (r)
        0: play_round(1, 3, 0, 0);
        1: play_round(1, -1, 3, 0);
        2: play_round(3, -1, 0, 1);
        3: play_round(4, 2, 0, 0);
        default:
          if (r < 9)
            play_round($urandom_range(0, 5), $urandom_range(0, 3),
                       $urandom_range(0, 3), 1'($urandom_range(0, 1)));
          else
            play_round(0, 0, 0, 0);
      endcase
    end
    over_check();

    // Game 2: restart from OVER, score a few rows, then reset mid-window.
    press_start();
    for (int r = 0; r < 3; r++) play_round(5, 3, $urandom_range(0, 3), 0);
    repeat (100) @(negedge div_clk);
    check("mid_play", bus.row_valid, 1);
    check("pre_reset_score", bus.total_score, m_score);
    #2 rst = 1'b0;
    #1 check("async_reset", outs(), RESET_OUTS);
    check("sb_empty_at_abort", sb.size(), 0);
    sb.delete();
    m_lfsr = SEED;
    repeat (3) @(negedge div_clk);
    check("reset_held", outs(), RESET_OUTS);
    #2 rst = 1'b1;
    repeat (4) @(negedge div_clk);

    // Game 3: long full-hit run past level 15, then timeouts to game over.
    press_start();
    for (int r = 0; r < 34; r++) begin
      md = $urandom_range(0, 2);
      case (md)
        0: play_round(1, ($urandom_range(0, 1) != 0) ? -1 : 3, $urandom_range(0, 3),
                      1'($urandom_range(0, 1)));
        1: play_round(3, 3, 0, 1'($urandom_range(0, 1)));
        default: play_round(5, 3, $urandom_range(0, 3), 1'($urandom_range(0, 1)));
      endcase
    end
    while (m_lives > 0) play_round(0, 0, 0, 0);
    over_check();
    check("level_cap", bus.level, 15);

    repeat (5) @(negedge div_clk);
    check("sb_drained", sb.size(), 0);
    $display("test done: total=%0d bad=%0d", n_total, n_bad);
    $finish;
  end

endmodule
